// File: rtl/accel_pkg.sv
// Shared types for the GEMM job scheduler: job descriptor layout and FSM states.
package accel_pkg;

  localparam int unsigned JOB_W = 194;

  typedef struct packed {
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic [31:0] addr_c;
    logic [31:0] m;
    logic [31:0] k;
    logic [31:0] n;
    logic        a_in_mode;
    logic        b_in_mode;
  } job_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    COMPLETE,
    ABORT
  } state_t;

endpackage

// File: rtl/job_fifo.sv
// Job descriptor FIFO: combinational head, occupancy count and a registered full flag.
module job_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             full_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/accel_job_scheduler.sv
// Launches queued GEMM jobs one at a time, guards each with a watchdog and
// reports completion/errors through sticky status bits and a level interrupt.
module accel_job_scheduler
  import accel_pkg::*;
#(
  parameter int unsigned JOB_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned ABORT_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [JOB_W-1:0] job_cfg,
  output logic [JOB_W-1:0] cfg_out,
  output logic             acc_start,
  input  logic             acc_done,
  output logic             acc_abort,
  output logic             busy,
  output logic [15:0]      jobs_done,
  output logic             err_timeout,
  output logic             err_zero,
  input  logic             err_clr,
  output logic             irq,
  input  logic             irq_clr
);

  localparam int unsigned CW = $clog2(JOB_DEPTH) + 1;

  logic [CW-1:0]    count;
  logic [JOB_W-1:0] head;
  logic             full;
  logic             push;
  logic             pop;
  logic             have_job;
  logic             zero_dim;
  job_t             head_job;

  state_t      state_q;
  job_t        cfg_q;
  logic [31:0] wd_q;
  logic        start_q;
  logic        abort_q;
  logic [15:0] jobs_done_q;
  logic        irq_q;
  logic        err_timeout_q;
  logic        err_zero_q;
  logic        irq_set_d;
  logic        timeout_set_d;
  logic        zero_set_d;

  assign push = job_valid & ~full;

  job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (job_cfg),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full)
  );

  assign head_job = job_t'(head);
  assign have_job = (count != '0);
  assign zero_dim = (head_job.m == '0) || (head_job.k == '0) || (head_job.n == '0);

  always_comb begin
    pop           = 1'b0;
    irq_set_d     = 1'b0;
    timeout_set_d = 1'b0;
    zero_set_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (have_job && zero_dim) begin
          pop        = 1'b1;
          zero_set_d = 1'b1;
          irq_set_d  = 1'b1;
        end
      end
      RUN: begin
        if (!acc_done && (wd_q == 32'(TIMEOUT_CYCLES - 1))) begin
          timeout_set_d = 1'b1;
          irq_set_d     = 1'b1;
        end
      end
      COMPLETE: begin
        pop       = 1'b1;
        irq_set_d = 1'b1;
      end
      ABORT: begin
        if (wd_q == 32'(ABORT_CYCLES - 1)) pop = 1'b1;
      end
      default: ;
    endcase
  end

  // The watchdog register doubles as the abort-pulse length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      wd_q          <= '0;
      start_q       <= 1'b0;
      abort_q       <= 1'b0;
      jobs_done_q   <= '0;
      irq_q         <= 1'b0;
      err_timeout_q <= 1'b0;
      err_zero_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (have_job && !zero_dim) begin
            cfg_q   <= head_job;
            start_q <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_q    <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (acc_done) begin
            state_q <= COMPLETE;
          end else if (timeout_set_d) begin
            wd_q    <= '0;
            abort_q <= 1'b1;
            state_q <= ABORT;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        COMPLETE: begin
          jobs_done_q <= jobs_done_q + 16'd1;
          state_q     <= IDLE;
        end
        ABORT: begin
          if (pop) begin
            abort_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
      irq_q         <= irq_set_d | (irq_q & ~irq_clr);
      err_timeout_q <= timeout_set_d | (err_timeout_q & ~err_clr);
      err_zero_q    <= zero_set_d | (err_zero_q & ~err_clr);
    end
  end

  assign job_ready   = ~full;
  assign cfg_out     = cfg_q;
  assign acc_start   = start_q;
  assign acc_abort   = abort_q;
  assign busy        = (state_q != IDLE) || have_job;
  assign jobs_done   = jobs_done_q;
  assign err_timeout = err_timeout_q;
  assign err_zero    = err_zero_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_accel_job_scheduler.sv
// Directed bench: one scheduler with a long watchdog, one with a 32-cycle watchdog, shared stimulus.
module tb_accel_job_scheduler;
  import accel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic acc_done = 1'b0;
  logic err_clr = 1'b0;
  logic irq_clr = 1'b0;
  logic [JOB_W-1:0] job_cfg = '0;

  logic ready, start, abort, busy, ez, et, irq;
  logic [JOB_W-1:0] cfg;
  logic [15:0] jdone;
  logic t_ready, t_start, t_abort, t_busy, t_ez, t_et, t_irq;
  logic [JOB_W-1:0] t_cfg;
  logic [15:0] t_jdone;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accel_job_scheduler #(.JOB_DEPTH(4), .TIMEOUT_CYCLES(1048576), .ABORT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(ready), .job_cfg(job_cfg),
    .cfg_out(cfg), .acc_start(start), .acc_done(acc_done), .acc_abort(abort), .busy(busy),
    .jobs_done(jdone), .err_timeout(et), .err_zero(ez), .err_clr(err_clr), .irq(irq), .irq_clr(irq_clr)
  );

  accel_job_scheduler #(.JOB_DEPTH(4), .TIMEOUT_CYCLES(32), .ABORT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(t_ready), .job_cfg(job_cfg),
    .cfg_out(t_cfg), .acc_start(t_start), .acc_done(acc_done), .acc_abort(t_abort), .busy(t_busy),
    .jobs_done(t_jdone), .err_timeout(t_et), .err_zero(t_ez), .err_clr(err_clr), .irq(t_irq), .irq_clr(irq_clr)
  );

  function automatic logic [JOB_W-1:0] mk(input logic [31:0] base, input logic [31:0] m,
                                          input logic [31:0] k, input logic [31:0] n);
    job_t j;
    j.addr_a = base;
    j.addr_b = base + 32'h100;
    j.addr_c = base + 32'h200;
    j.m = m;
    j.k = k;
    j.n = n;
    j.a_in_mode = base[4];
    j.b_in_mode = 1'b1;
    return j;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    job_valid = 1'b0;
    acc_done = 1'b0;
    err_clr = 1'b0;
    irq_clr = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic wait_start(input bit sel, input int maxc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if ((sel ? t_start : start) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if ({start, abort, busy, ez, et, irq} !== 6'b0) begin failures++; $display("FAIL reset_flags: got %b expected 000000", {start, abort, busy, ez, et, irq}); end
    checks++; if (cfg !== '0) begin failures++; $display("FAIL reset_cfg: got %h expected 0", cfg); end
    checks++; if (jdone !== 16'd0) begin failures++; $display("FAIL reset_jobs_done: got %0d expected 0", jdone); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
  endtask

  task automatic test_single;
    logic [JOB_W-1:0] j;
    j = mk(32'h1000, 16, 16, 16);
    do_reset;
    job_cfg = j; job_valid = 1'b1; tick; job_valid = 1'b0;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_t1: got %b expected 0", start); end
    tick;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL single_start_t2: got %b expected 1", start); end
    checks++; if (cfg !== j) begin failures++; $display("FAIL single_cfg: got %h expected %h", cfg, j); end
    tick;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_t3: got %b expected 0", start); end
    repeat (99) tick;
    acc_done = 1'b1; tick; acc_done = 1'b0;
    checks++; if ({busy, irq} !== 2'b10) begin failures++; $display("FAIL single_complete_busy_irq: got %b expected 10", {busy, irq}); end
    tick;
    checks++; if (jdone !== 16'd1) begin failures++; $display("FAIL single_jobs_done: got %0d expected 1", jdone); end
    checks++; if ({irq, busy} !== 2'b10) begin failures++; $display("FAIL single_irq_busy: got %b expected 10", {irq, busy}); end
  endtask

  task automatic test_fill;
    logic [JOB_W-1:0] jobs [5];
    bit stable;
    for (int i = 0; i < 5; i++) jobs[i] = mk(32'h2000 + 32'(i) * 32'h40, 32'(i + 1), 2, 3);
    do_reset;
    job_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      job_cfg = jobs[i];
      tick;
    end
    job_cfg = jobs[4];
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fill_full: got %b expected 0", ready); end
    stable = 1'b1;
    repeat (10) begin
      tick;
      if (cfg !== jobs[0] || ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL fill_cfg_stable: got %h expected %h", cfg, jobs[0]); end
    acc_done = 1'b1; tick; acc_done = 1'b0;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fill_complete_ready: got %b expected 0", ready); end
    tick;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fill_reopen: got %b expected 1", ready); end
    tick; job_valid = 1'b0;
    checks++; if ({start, ready} !== 2'b10) begin failures++; $display("FAIL fill_launch1_start_ready: got %b expected 10", {start, ready}); end
    checks++; if (cfg !== jobs[1]) begin failures++; $display("FAIL fill_cfg1: got %h expected %h", cfg, jobs[1]); end
    for (int i = 1; i < 5; i++) begin
      if (i > 1) begin
        tick;
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL b2b_idle_start: got %b expected 0", start); end
        tick;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL b2b_launch_start: got %b expected 1", start); end
        checks++; if (cfg !== jobs[i]) begin failures++; $display("FAIL b2b_cfg: got %h expected %h", cfg, jobs[i]); end
      end
      tick;
      acc_done = 1'b1; tick; acc_done = 1'b0;
    end
    tick;
    checks++; if (jdone !== 16'd5) begin failures++; $display("FAIL fill_jobs_done: got %0d expected 5", jdone); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fill_drained_busy: got %b expected 0", busy); end
  endtask

  task automatic test_zero;
    logic [JOB_W-1:0] z, v;
    z = mk(32'h3000, 4, 0, 4);
    v = mk(32'h3400, 5, 6, 7);
    do_reset;
    job_valid = 1'b1; job_cfg = z; tick;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL zero_start_c1: got %b expected 0", start); end
    job_cfg = v; tick; job_valid = 1'b0;
    checks++; if ({start, ez, irq} !== 3'b011) begin failures++; $display("FAIL zero_reject_start_err_irq: got %b expected 011", {start, ez, irq}); end
    checks++; if (jdone !== 16'd0) begin failures++; $display("FAIL zero_jobs_done: got %0d expected 0", jdone); end
    tick;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL zero_second_start: got %b expected 1", start); end
    checks++; if (cfg !== v) begin failures++; $display("FAIL zero_second_cfg: got %h expected %h", cfg, v); end
  endtask

  task automatic test_timeout;
    bit held;
    do_reset;
    job_cfg = mk(32'h4000, 8, 8, 8); job_valid = 1'b1; tick; job_valid = 1'b0;
    tick;
    checks++; if (t_start !== 1'b1) begin failures++; $display("FAIL to_start: got %b expected 1", t_start); end
    tick;
    repeat (31) tick;
    checks++; if ({t_abort, t_et} !== 2'b00) begin failures++; $display("FAIL to_run31: got %b expected 00", {t_abort, t_et}); end
    tick;
    checks++; if ({t_abort, t_et, t_irq} !== 3'b111) begin failures++; $display("FAIL to_abort_begin: got %b expected 111", {t_abort, t_et, t_irq}); end
    held = 1'b1;
    repeat (3) begin
      tick;
      if (t_abort !== 1'b1) held = 1'b0;
    end
    checks++; if (!held || t_busy !== 1'b1) begin failures++; $display("FAIL to_abort_hold: got abort_held=%b busy=%b expected 1 1", held, t_busy); end
    tick;
    checks++; if ({t_abort, t_busy, t_start} !== 3'b000) begin failures++; $display("FAIL to_abort_end: got %b expected 000", {t_abort, t_busy, t_start}); end
    do_reset;
    job_cfg = mk(32'h4400, 8, 8, 8); job_valid = 1'b1; tick; job_valid = 1'b0;
    tick;
    tick;
    repeat (31) tick;
    acc_done = 1'b1; tick; acc_done = 1'b0;
    checks++; if (t_abort !== 1'b0) begin failures++; $display("FAIL to_done_wins_abort: got %b expected 0", t_abort); end
    tick;
    checks++; if ({t_jdone, t_et, t_abort} !== {16'd1, 2'b00}) begin failures++; $display("FAIL to_done_wins_status: got %0d %b %b expected 1 0 0", t_jdone, t_et, t_abort); end
  endtask

  task automatic test_irq;
    bit seen;
    do_reset;
    job_valid = 1'b1;
    job_cfg = mk(32'h5000, 3, 3, 0); tick;
    job_cfg = mk(32'h5100, 3, 3, 3); tick;
    job_cfg = mk(32'h5200, 4, 4, 4); tick;
    job_valid = 1'b0;
    tick;
    wait_start(1'b1, 60, seen);
    checks++; if (!seen) begin failures++; $display("FAIL irq_second_launch_wait: got no start expected start within 60 cycles"); end
    checks++; if ({t_ez, t_et, t_irq} !== 3'b111) begin failures++; $display("FAIL irq_errors_set: got %b expected 111", {t_ez, t_et, t_irq}); end
    tick;
    acc_done = 1'b1; tick; acc_done = 1'b0;
    irq_clr = 1'b1; tick; irq_clr = 1'b0;
    checks++; if ({t_irq, t_jdone} !== {1'b1, 16'd1}) begin failures++; $display("FAIL irq_set_over_clear: got %b %0d expected 1 1", t_irq, t_jdone); end
    irq_clr = 1'b1; tick; irq_clr = 1'b0;
    checks++; if ({t_irq, t_ez, t_et} !== 3'b011) begin failures++; $display("FAIL irq_clr_only: got %b expected 011", {t_irq, t_ez, t_et}); end
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checks++; if ({t_irq, t_ez, t_et} !== 3'b000) begin failures++; $display("FAIL err_clr_both: got %b expected 000", {t_irq, t_ez, t_et}); end
  endtask

  task automatic test_reset_mid;
    bit quiet;
    do_reset;
    job_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      job_cfg = mk(32'h6000 + 32'(i) * 32'h10, 2, 2, 2);
      tick;
    end
    job_valid = 1'b0;
    acc_done = 1'b1; tick; acc_done = 1'b0;
    tick;
    tick;
    tick;
    checks++; if ({jdone, busy, irq} !== {16'd1, 2'b11}) begin failures++; $display("FAIL mid_pre_reset: got %0d %b %b expected 1 1 1", jdone, busy, irq); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({start, abort, busy, ez, et, irq, ready} !== 7'b0000001) begin failures++; $display("FAIL mid_async_flags: got %b expected 0000001", {start, abort, busy, ez, et, irq, ready}); end
    checks++; if (cfg !== '0 || jdone !== 16'd0) begin failures++; $display("FAIL mid_async_cfg_count: got %h %0d expected 0 0", cfg, jdone); end
    tick;
    tick;
    rst = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      tick;
      if (start !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL mid_no_relaunch: got start=%b busy=%b expected 0 0", start, busy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_zero;
    test_timeout;
    test_irq;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no completion expected finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/accel_job_scheduler.md
Name: accel_job_scheduler

Overview:
- Queues matrix-multiply jobs written by the CPU-side CSR logic and launches them one at a time on the GEMM control/DMA datapath.
- Presents stable configuration (bases, m/k/n, modes) plus a one-cycle start pulse, then waits for the datapath's done pulse.
- Guards each job with a watchdog and reports completion and errors through an interrupt and sticky status bits.
- Sits between the CSR block and the accelerator control register block.

Parameters:
JOB_DEPTH, 4, job queue entries (power of 2, >=2)
TIMEOUT_CYCLES, 1048576, RUN-state cycles before abort
ABORT_CYCLES, 4, width of acc_abort pulse

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
job_valid  in  1  CSR offers a job
job_ready  out  1  queue not full
job_cfg  in  194  packed job_t {addr_a, addr_b, addr_c, m, k, n (32b each), a_in_mode, b_in_mode}
cfg_out  out  194  job_t driven to datapath; held stable LAUNCH..RUN
acc_start  out  1  one-cycle start pulse
acc_done  in  1  datapath completion pulse
acc_abort  out  1  datapath abort, ABORT_CYCLES long
busy  out  1  state!=IDLE or queue non-empty
jobs_done  out  16  completed-job counter, wraps
err_timeout  out  1  sticky watchdog error
err_zero  out  1  sticky zero-dimension error
err_clr  in  1  clears both error bits
irq  out  1  level interrupt
irq_clr  in  1  clears irq

Behaviour:
- Reset (async, any time): queue emptied; FSM IDLE; acc_start=0, acc_abort=0, cfg_out=0, jobs_done=0, err_*=0, irq=0, busy=0. Mid-job reset drops the job silently.
- Queue: FIFO with count register 0..JOB_DEPTH. job_ready = (count!=JOB_DEPTH), registered. Push on job_valid&job_ready. Pop only in COMPLETE/ABORT-exit/zero-reject. Simultaneous push+pop leaves count unchanged.
- FSM states:
  - IDLE: if count!=0, check the head entry.
    - If head m, k or n ==0: pop, set err_zero, set irq; stay IDLE; no start.
    - Else: load cfg_out <= head -> LAUNCH.
  - LAUNCH: acc_start=1 for exactly this cycle; clear watchdog -> RUN.
  - RUN: watchdog increments each cycle.
    - acc_done -> COMPLETE.
    - Else if watchdog==TIMEOUT_CYCLES-1 -> ABORT.
    - acc_done in the same cycle as the timeout: done wins.
  - COMPLETE (1 cycle): pop; jobs_done+1 (16b wrap); set irq -> IDLE.
  - ABORT: acc_abort=1 for ABORT_CYCLES cycles; set err_timeout, set irq; on the last cycle pop -> IDLE.
- Latency: a job pushed at cycle t into an empty queue while IDLE gives acc_start high in cycle t+2. Back-to-back jobs: acc_start of the next job is 3 cycles after the acc_done cycle (COMPLETE, IDLE, LAUNCH).
- acc_done outside RUN is ignored.
- irq/err: set-over-clear when set and clear occur in the same cycle. irq_clr clears irq only; err_clr clears both err bits only.
- cfg_out changes only on IDLE->LAUNCH.
- Widths: watchdog 32b; count $clog2(JOB_DEPTH)+1 bits.

Decomposition:
- Package accel_pkg holds:
  - job_t struct (field order above, addr_a at MSB);
  - JOB_W=194;
  - state enum {IDLE, LAUNCH, RUN, COMPLETE, ABORT}.
- One sub-module: job_fifo (parameterised width/depth, count output, registered full). FSM, watchdog and status live in the top.

Test Plan:
- Single job (m=k=n=16): push at t -> acc_start high only at t+2; drive acc_done 100 cycles later -> jobs_done=1, irq=1, busy=0 two cycles after done.
- Fill queue: 5 pushes, no done -> job_ready=0 after 4th accepted; the 5th is held until the first COMPLETE, then accepted; cfg_out is unchanged during RUN.
- Zero dim (k=0) at head followed by a valid job -> err_zero=1, no acc_start for the first job, acc_start for the second; jobs_done unchanged by the rejected job.
- Timeout with TIMEOUT_CYCLES=32: no acc_done -> acc_abort high for 4 cycles starting at RUN cycle 32; err_timeout=1; queue count decremented. Repeat with acc_done on cycle 31 -> COMPLETE, no error.
- irq_clr and a completion in the same cycle -> irq stays 1. err_clr then clears both error bits.
- Assert rst in RUN with 3 queued jobs -> all outputs zero immediately (async); after release, busy=0 and acc_start is not re-issued.
